// File: rtl/neuron_delta_pkg.sv
// Shared definitions for the backward-pass neuron stage: mode encoding, error-lane
// width and the signed saturation limits reused by the weight-update block.
package neuron_delta_pkg;

  typedef enum logic {
    MODE_TEST  = 1'b0,
    MODE_TRAIN = 1'b1
  } mode_e;

  // Width of one back-propagated error lane: sum of NN products of WF-bit values.
  function automatic int errWidth(input int nn, input int wf);
    return $clog2(nn) + 1 + wf;
  endfunction

  function automatic int maxD(input int wf);
    return (1 << (wf - 1)) - 1;
  endfunction

  function automatic int minD(input int wf);
    return -(1 << (wf - 1));
  endfunction

endpackage

// File: rtl/neuron_delta_fifo.sv
// Activation buffer: DEPTH x WIDTH synchronous FIFO with synchronous flush,
// wrap-bit pointers and an occupancy count.
module neuron_delta_fifo #(
  parameter int  WIDTH = 16,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iFlush,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oData,
  output logic             oFull,
  output logic             oEmpty,
  output logic [AW:0]      oCount
);

  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             doPush;
  logic             doPop;

  assign oFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign oEmpty = (wrPtr == rdPtr);
  assign oCount = wrPtr - rdPtr;
  assign oData  = mem[rdPtr[AW-1:0]];
  assign doPush = iPush && !oFull && !iFlush;
  assign doPop  = iPop && !oEmpty;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (iFlush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW + 1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW + 1)'(1);
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge iCLK) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= iData;
  end

endmodule

// File: rtl/neuron_delta.sv
// Backward-pass neuron stage: buffers TRAIN-mode activations, joins each with its
// error sum in order, and registers the ReLU/clip-gated, saturated delta.
module neuron_delta
  import neuron_delta_pkg::*;
#(
  parameter int  NC        = 4,
  parameter int  WF        = 4,
  parameter int  NN        = 4,
  parameter int  DEPTH     = 4,
  parameter      CLIP_GRAD = "yes",
  localparam int WE        = errWidth(NN, WF),
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iMode,
  input  logic             iValid_AM_State0,
  output logic             oReady_AM_State0,
  input  logic [NC*WF-1:0] iData_AM_State0,
  input  logic             iValid_AM_Error0,
  output logic             oReady_AM_Error0,
  input  logic [NC*WE-1:0] iData_AM_Error0,
  output logic             oValid_BM_Delta0,
  input  logic             iReady_BM_Delta0,
  output logic [NC*WF-1:0] oData_BM_Delta0,
  output logic [CW-1:0]    oCount
);

  localparam bit                     CLIP    = (CLIP_GRAD == "yes");
  localparam logic signed [WE-1:0]   ERR_MAX = WE'(maxD(WF));
  localparam logic signed [WE-1:0]   ERR_MIN = WE'(minD(WF));
  localparam logic        [WF-1:0]   MAX_D   = WF'(maxD(WF));
  localparam logic        [WF-1:0]   MIN_D   = WF'(minD(WF));

  mode_e            modeReg;
  logic             isTrain;
  logic             modeFlush;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [NC*WF-1:0] fifoHead;
  logic             pushEn;
  logic             joinFire;
  logic [NC*WF-1:0] deltaNext;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) modeReg <= MODE_TEST;
    else         modeReg <= mode_e'(iMode);
  end

  // A mode change empties the buffer on the very edge that updates modeReg.
  assign isTrain   = (modeReg == MODE_TRAIN);
  assign modeFlush = (mode_e'(iMode) != modeReg);

  assign oReady_AM_State0 = isTrain ? !fifoFull : 1'b1;
  assign pushEn           = iValid_AM_State0 && isTrain && !fifoFull && !modeFlush;
  assign oReady_AM_Error0 = isTrain && !fifoEmpty && (!oValid_BM_Delta0 || iReady_BM_Delta0);
  assign joinFire         = iValid_AM_Error0 && oReady_AM_Error0;

  neuron_delta_fifo #(
    .WIDTH (NC * WF),
    .DEPTH (DEPTH)
  ) u_fifo (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iFlush (modeFlush),
    .iPush  (pushEn),
    .iData  (iData_AM_State0),
    .iPop   (joinFire),
    .oData  (fifoHead),
    .oFull  (fifoFull),
    .oEmpty (fifoEmpty),
    .oCount (oCount)
  );

  for (genvar i = 0; i < NC; i++) begin : g_lane
    logic signed [WE-1:0] err;
    logic        [WF-1:0] act;
    logic        [WF-1:0] eSat;
    logic                 gate;

    assign err  = iData_AM_Error0[i*WE +: WE];
    assign act  = fifoHead[i*WF +: WF];
    assign eSat = (err > ERR_MAX) ? MAX_D :
                  (err < ERR_MIN) ? MIN_D : err[WF-1:0];
    // Activation MSB set is read as non-positive; a pinned-at-max activation is flat.
    assign gate = !act[WF-1] && (act != '0) && !(CLIP && (act == MAX_D));
    assign deltaNext[i*WF +: WF] = gate ? eSat : '0;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oValid_BM_Delta0 <= 1'b0;
      oData_BM_Delta0  <= '0;
    end else if (joinFire) begin
      oValid_BM_Delta0 <= 1'b1;
      oData_BM_Delta0  <= deltaNext;
    end else if (iReady_BM_Delta0) begin
      oValid_BM_Delta0 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_delta.sv
// Scoreboard bench for neuron_delta: a queue-level model predicts handshakes and
// deltas; a separate monitor pops expected deltas as the DUT emits them.
module tb_neuron_delta;
  import neuron_delta_pkg::*;

  localparam int NC    = 2;
  localparam int WF    = 4;
  localparam int NN    = 4;
  localparam int WE    = 7;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             iMode = MODE_TRAIN;
  logic             iValid_AM_State0 = 1'b0;
  logic             oReady_AM_State0;
  logic [NC*WF-1:0] iData_AM_State0 = '0;
  logic             iValid_AM_Error0 = 1'b0;
  logic             oReady_AM_Error0;
  logic [NC*WE-1:0] iData_AM_Error0 = '0;
  logic             oValid_BM_Delta0;
  logic             iReady_BM_Delta0 = 1'b1;
  logic [NC*WF-1:0] oData_BM_Delta0;
  logic [CW-1:0]    oCount;

  int errors = 0;
  int checks = 0;

  // Reference state: buffered activations, expected deltas, registered mode, output-valid.
  logic [NC*WF-1:0] actQ[$];
  logic [NC*WF-1:0] expQ[$];
  logic             modelMode;
  logic             modelOutValid;

  always #5 clk = ~clk;

  neuron_delta #(
    .NC(NC), .WF(WF), .NN(NN), .DEPTH(DEPTH), .CLIP_GRAD("yes")
  ) dut (
    .iCLK             (clk),
    .iRST_N           (rst_n),
    .iMode            (iMode),
    .iValid_AM_State0 (iValid_AM_State0),
    .oReady_AM_State0 (oReady_AM_State0),
    .iData_AM_State0  (iData_AM_State0),
    .iValid_AM_Error0 (iValid_AM_Error0),
    .oReady_AM_Error0 (oReady_AM_Error0),
    .iData_AM_Error0  (iData_AM_Error0),
    .oValid_BM_Delta0 (oValid_BM_Delta0),
    .iReady_BM_Delta0 (iReady_BM_Delta0),
    .oData_BM_Delta0  (oData_BM_Delta0),
    .oCount           (oCount)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Delta from plain integer arithmetic on each lane.
  function automatic logic [NC*WF-1:0] refDelta(input logic [NC*WF-1:0] a, input logic [NC*WE-1:0] e);
    logic [NC*WF-1:0] r;
    for (int i = 0; i < NC; i++) begin
      int av, ev, s;
      av = int'(a[i*WF +: WF]);
      ev = int'($signed(e[i*WE +: WE]));
      s  = (ev > 7) ? 7 : ((ev < -8) ? -8 : ev);
      r[i*WF +: WF] = (av > 0 && av < 8 && av != 7) ? s[WF-1:0] : 4'd0;
    end
    return r;
  endfunction

  function automatic logic [NC*WF-1:0] acts(input int l1, input int l0);
    return {l1[WF-1:0], l0[WF-1:0]};
  endfunction

  function automatic logic [NC*WE-1:0] errs(input int l1, input int l0);
    return {l1[WE-1:0], l0[WE-1:0]};
  endfunction

  function automatic void modelReset();
    actQ.delete();
    expQ.delete();
    modelMode     = MODE_TEST;
    modelOutValid = 1'b0;
  endfunction

  // One clock: drive at negedge, check the model's view, then advance the model past the posedge.
  task automatic cycle(input logic v, input logic [NC*WF-1:0] a, input logic ev,
                       input logic [NC*WE-1:0] e, input logic rdy, input logic m);
    logic expRs, expRe, flush, pushOk;
    @(negedge clk);
    iValid_AM_State0 = v;
    iData_AM_State0  = a;
    iValid_AM_Error0 = ev;
    iData_AM_Error0  = e;
    iReady_BM_Delta0 = rdy;
    iMode            = m;
    #1;
    expRs = (modelMode == MODE_TRAIN) ? (actQ.size() < DEPTH) : 1'b1;
    expRe = (modelMode == MODE_TRAIN) && (actQ.size() > 0) && (!modelOutValid || rdy);
    check("readyState", 32'(oReady_AM_State0), 32'(expRs));
    check("readyError", 32'(oReady_AM_Error0), 32'(expRe));
    check("count", 32'(oCount), 32'(actQ.size()));
    check("validOut", 32'(oValid_BM_Delta0), 32'(modelOutValid));
    flush  = (m != modelMode);
    pushOk = v && (modelMode == MODE_TRAIN) && (actQ.size() < DEPTH) && !flush;
    if (ev && expRe) expQ.push_back(refDelta(actQ[0], e));
    if (flush) actQ.delete();
    else begin
      if (ev && expRe) void'(actQ.pop_front());
      if (pushOk) actQ.push_back(a);
    end
    if (ev && expRe) modelOutValid = 1'b1;
    else if (rdy)    modelOutValid = 1'b0;
    modelMode = m;
  endtask

  task automatic idle(input int n, input logic rdy, input logic m);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, rdy, m);
  endtask

  // Monitor: pops the scoreboard on each output transfer and watches hold-while-stalled.
  initial begin
    logic             heldPrev;
    logic [NC*WF-1:0] prevData;
    heldPrev = 1'b0;
    prevData = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        heldPrev = 1'b0;
      end else begin
        if (heldPrev) begin
          check("holdValid", 32'(oValid_BM_Delta0), 32'd1);
          check("holdData", 32'(oData_BM_Delta0), 32'(prevData));
        end
        if (oValid_BM_Delta0 && iReady_BM_Delta0) begin
          if (expQ.size() == 0) check("unexpectedDelta", 32'(oData_BM_Delta0), 32'hDEAD);
          else check("delta", 32'(oData_BM_Delta0), 32'(expQ.pop_front()));
        end
        heldPrev = oValid_BM_Delta0 && !iReady_BM_Delta0;
        prevData = oData_BM_Delta0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    modelReset();
    // Reset values while held in reset with TRAIN requested.
    #12;
    check("rstValid", 32'(oValid_BM_Delta0), 32'd0);
    check("rstData", 32'(oData_BM_Delta0), 32'd0);
    check("rstCount", 32'(oCount), 32'd0);
    check("rstReadyState", 32'(oReady_AM_State0), 32'd1);
    check("rstReadyError", 32'(oReady_AM_Error0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b1, MODE_TRAIN);

    // Basic join.
    cycle(1'b1, acts(0, 3), 1'b0, '0, 1'b1, MODE_TRAIN);
    cycle(1'b0, '0, 1'b1, errs(-2, 5), 1'b1, MODE_TRAIN);
    idle(2, 1'b1, MODE_TRAIN);

    // Saturation and clip.
    cycle(1'b1, acts(1, 1), 1'b0, '0, 1'b1, MODE_TRAIN);
    cycle(1'b1, acts(7, 2), 1'b1, errs(-20, 20), 1'b1, MODE_TRAIN);
    cycle(1'b0, '0, 1'b1, errs(3, 3), 1'b1, MODE_TRAIN);
    idle(2, 1'b1, MODE_TRAIN);

    // Fill past capacity, then join once under backpressure.
    for (int i = 0; i < 5; i++) cycle(1'b1, acts(i + 1, 2), 1'b0, '0, 1'b1, MODE_TRAIN);
    cycle(1'b1, acts(5, 5), 1'b1, errs(4, -3), 1'b0, MODE_TRAIN);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, errs(1, 1), 1'b0, MODE_TRAIN);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, errs(i, -i), 1'b1, MODE_TRAIN);
    idle(2, 1'b1, MODE_TRAIN);

    // Ordering with simultaneous push and pop.
    cycle(1'b1, acts(1, 2), 1'b0, '0, 1'b1, MODE_TRAIN);
    cycle(1'b1, acts(3, 4), 1'b1, errs(6, -6), 1'b1, MODE_TRAIN);
    cycle(1'b1, acts(5, 6), 1'b1, errs(-1, 2), 1'b1, MODE_TRAIN);
    cycle(1'b0, '0, 1'b1, errs(30, -30), 1'b1, MODE_TRAIN);
    idle(2, 1'b1, MODE_TRAIN);

    // Mode flush with a stalled delta pending.
    cycle(1'b1, acts(2, 3), 1'b0, '0, 1'b1, MODE_TRAIN);
    cycle(1'b1, acts(4, 1), 1'b0, '0, 1'b1, MODE_TRAIN);
    cycle(1'b1, acts(1, 1), 1'b1, errs(5, 6), 1'b0, MODE_TRAIN);
    cycle(1'b1, acts(1, 1), 1'b1, errs(1, 1), 1'b0, MODE_TEST);
    cycle(1'b1, acts(1, 1), 1'b1, errs(1, 1), 1'b0, MODE_TEST);
    idle(2, 1'b1, MODE_TEST);
    idle(2, 1'b1, MODE_TRAIN);

    // Randomized traffic with occasional mode toggles.
    begin
      logic m;
      m = MODE_TRAIN;
      for (int n = 0; n < 1500; n++) begin
        logic [NC*WE-1:0] e;
        if ($urandom_range(63) == 0) m = ~m;
        if ($urandom_range(1) == 0) e = $urandom;
        else e = errs($urandom_range(16) - 8, $urandom_range(16) - 8);
        cycle($urandom_range(9) < 6, NC*WF'($urandom), $urandom_range(9) < 6, e,
              $urandom_range(9) < 7, m);
      end
    end

    // Asynchronous reset in the middle of traffic.
    cycle(1'b1, acts(3, 3), 1'b1, errs(2, 2), 1'b0, MODE_TRAIN);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midRstValid", 32'(oValid_BM_Delta0), 32'd0);
    check("midRstData", 32'(oData_BM_Delta0), 32'd0);
    check("midRstCount", 32'(oCount), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1'b1, MODE_TRAIN);
    cycle(1'b1, acts(6, 2), 1'b0, '0, 1'b1, MODE_TRAIN);
    cycle(1'b0, '0, 1'b1, errs(-9, 9), 1'b1, MODE_TRAIN);

    idle(6, 1'b1, MODE_TRAIN);
    @(negedge clk);
    #5;
    check("scoreboardDrained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
